// File: rtl/ifu_pkg.sv
// Shared types for the instruction fetch unit: reset PC, controller states and fetch-queue entry.
package ifu_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
    localparam int unsigned INST_W           = 128;

    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1,
        ST_FULL = 2'd2,
        ST_HALT = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]       pc;
        logic [INST_W-1:0] inst;
        logic [3:0]        mask;
        logic              exc;
    } fetch_entry_t;

    // Valid-instruction mask for a line entered at word offset word_off.
    function automatic logic [3:0] offset_mask(input logic [1:0] word_off);
        return 4'(4'b1111 << word_off);
    endfunction

endpackage

// File: rtl/ifu_fetch_queue.sv
// Synchronous FIFO of fetched lines with flush and occupancy count; head is zero while empty.
module ifu_fetch_queue
    import ifu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    output fetch_entry_t           head,
    output logic                   valid,
    output logic [$clog2(DEPTH):0] count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push, do_pop;

    always_comb begin
        mem_d   = mem_q;
        wr_d    = wr_q;
        rd_d    = rd_q;
        cnt_d   = cnt_q;
        do_pop  = pop && (cnt_q != '0);
        do_push = push && ((cnt_q != DEPTH_C) || do_pop);
        // Flush wins over any push or pop in the same cycle.
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_q] = push_data;
                wr_d        = wr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_d = rd_q + PTR_W'(1);
            end
            cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign valid = (cnt_q != '0);
    assign head  = valid ? mem_q[rd_q] : '0;
    assign count = cnt_q;

endmodule

// File: rtl/ifu_fetch_ctrl.sv
// Instruction fetch controller: issues line requests to the icache and queues returned lines for decode.
// Optional stall counter enabled by defining IFU_PERF_CNT_EN.
module ifu_fetch_ctrl
    import ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int unsigned FQ_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              inst_req,
    output logic              inst_wr,
    output logic [1:0]        inst_size,
    output logic [31:0]       inst_wdata,
    output logic              inst_hasException,
    output logic [7:0]        inst_index,
    output logic [19:0]       inst_tag,
    output logic              inst_unCache,
    input  logic              inst_index_ok,
    input  logic              inst_data_ok,
    input  logic [INST_W-1:0] inst_rdata,
    input  logic              redirect_valid,
    input  logic [31:0]       redirect_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_pc,
    output logic [INST_W-1:0] out_inst,
    output logic [3:0]        out_mask,
    output logic              out_exc,
    output logic [31:0]       perf_stall_cnt
);

    localparam int unsigned CNT_W = $clog2(FQ_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FQ_DEPTH);

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d, req_pc_q, req_pc_d;
    logic             discard_q, discard_d;
    logic             inst_req_q, inst_req_d;
    logic             accept, push_ok;
    logic             fq_push, fq_pop, fq_flush, fq_valid;
    fetch_entry_t     fq_wdata, fq_head;
    logic [CNT_W-1:0] fq_count, count_nxt;

    ifu_fetch_queue #(
        .DEPTH (FQ_DEPTH)
    ) u_queue (
        .clk       (clk),
        .rst_n     (rst),
        .flush     (fq_flush),
        .push      (fq_push),
        .push_data (fq_wdata),
        .pop       (fq_pop),
        .head      (fq_head),
        .valid     (fq_valid),
        .count     (fq_count)
    );

    assign accept = inst_req_q && inst_index_ok;
    assign fq_pop = fq_valid && out_ready;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        req_pc_d  = req_pc_q;
        discard_d = discard_q && !inst_data_ok;
        fq_push   = 1'b0;
        fq_wdata  = '0;
        fq_flush  = 1'b0;
        push_ok   = 1'b0;
        count_nxt = fq_count;

        if (redirect_valid) begin
            // A line still owed by the icache must be swallowed before the new pc is fetched.
            fq_flush  = 1'b1;
            pc_d      = redirect_pc;
            state_d   = ST_REQ;
            discard_d = (discard_q && !inst_data_ok)
                      || (state_q == ST_WAIT && !inst_data_ok)
                      || accept;
        end else begin
            case (state_q)
                ST_REQ: begin
                    if (discard_q) begin
                        state_d = ST_REQ;
                    end else if (pc_q[1:0] != 2'b00) begin
                        if (fq_count < DEPTH_C) begin
                            fq_push       = 1'b1;
                            fq_wdata.pc   = pc_q;
                            fq_wdata.exc  = 1'b1;
                            state_d       = ST_HALT;
                        end else begin
                            state_d = ST_FULL;
                        end
                    end else if (fq_count >= DEPTH_C) begin
                        state_d = ST_FULL;
                    end else if (accept) begin
                        state_d  = ST_WAIT;
                        req_pc_d = pc_q;
                        pc_d     = {pc_q[31:4] + 28'd1, 4'b0000};
                    end
                end
                ST_WAIT: begin
                    if (inst_data_ok) begin
                        fq_push       = 1'b1;
                        fq_wdata.pc   = req_pc_q;
                        fq_wdata.inst = inst_rdata;
                        fq_wdata.mask = offset_mask(req_pc_q[3:2]);
                        state_d       = ST_REQ;
                    end
                end
                ST_FULL: begin
                    if (fq_count < DEPTH_C) begin
                        state_d = ST_REQ;
                    end
                end
                ST_HALT: begin
                    state_d = ST_HALT;
                end
            endcase
        end

        // Request flop is computed from next-cycle state so it lines up with state_q in REQ.
        push_ok = fq_push && ((fq_count < DEPTH_C) || fq_pop);
        if (fq_flush) begin
            count_nxt = '0;
        end else begin
            count_nxt = fq_count + CNT_W'(push_ok) - CNT_W'(fq_pop);
        end
        inst_req_d = (state_d == ST_REQ) && !discard_d
                   && (pc_d[1:0] == 2'b00) && (count_nxt < DEPTH_C);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_REQ;
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            discard_q  <= 1'b0;
            inst_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            discard_q  <= discard_d;
            inst_req_q <= inst_req_d;
        end
    end

`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_q, perf_d;

    always_comb begin
        perf_d = perf_q;
        if (state_q == ST_FULL || (state_q == ST_WAIT && !inst_data_ok)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_q <= '0;
        end else begin
            perf_q <= perf_d;
        end
    end

    assign perf_stall_cnt = perf_q;
`else
    assign perf_stall_cnt = '0;
`endif

    assign inst_req          = inst_req_q;
    assign inst_wr           = 1'b0;
    assign inst_size         = 2'b10;
    assign inst_wdata        = '0;
    assign inst_hasException = 1'b0;
    assign inst_index        = pc_q[11:4];
    assign inst_tag          = pc_q[31:12];
    assign inst_unCache      = (pc_q[31:29] == 3'b101);

    assign out_valid = fq_valid;
    assign out_pc    = fq_head.pc;
    assign out_inst  = fq_head.inst;
    assign out_mask  = fq_head.mask;
    assign out_exc   = fq_head.exc;

endmodule

// File: tb/tb_ifu_fetch_ctrl.sv
// Directed bench for ifu_fetch_ctrl: fill/stall, redirect with discard, misaligned halt, async reset.
module tb_ifu_fetch_ctrl;
    import ifu_pkg::*;

    logic         clk = 1'b0;
    logic         rst;
    logic         inst_req, inst_wr, inst_hasException, inst_unCache;
    logic [1:0]   inst_size;
    logic [31:0]  inst_wdata;
    logic [7:0]   inst_index;
    logic [19:0]  inst_tag;
    logic         inst_index_ok, inst_data_ok;
    logic [127:0] inst_rdata;
    logic         redirect_valid;
    logic [31:0]  redirect_pc;
    logic         out_valid, out_ready, out_exc;
    logic [31:0]  out_pc, perf_stall_cnt;
    logic [127:0] out_inst;
    logic [3:0]   out_mask;

    int n_checks = 0;
    int n_errors = 0;

    ifu_fetch_ctrl dut (
        .clk               (clk),
        .rst               (rst),
        .inst_req          (inst_req),
        .inst_wr           (inst_wr),
        .inst_size         (inst_size),
        .inst_wdata        (inst_wdata),
        .inst_hasException (inst_hasException),
        .inst_index        (inst_index),
        .inst_tag          (inst_tag),
        .inst_unCache      (inst_unCache),
        .inst_index_ok     (inst_index_ok),
        .inst_data_ok      (inst_data_ok),
        .inst_rdata        (inst_rdata),
        .redirect_valid    (redirect_valid),
        .redirect_pc       (redirect_pc),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_pc            (out_pc),
        .out_inst          (out_inst),
        .out_mask          (out_mask),
        .out_exc           (out_exc),
        .perf_stall_cnt    (perf_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (inst_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_req"}, 128'(inst_req), 128'(1));
    endtask

    // One line: request accepted on the next edge, data returned the edge after.
    task automatic fetch_one(input string tag, input logic [127:0] data);
        wait_req(tag);
        tick();
        inst_data_ok = 1'b1;
        inst_rdata   = data;
        tick();
        inst_data_ok = 1'b0;
        inst_rdata   = '0;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc, input logic [127:0] data,
                              input logic [3:0] mask, input logic exc);
        check({tag, "_valid"}, 128'(out_valid), 128'(1));
        check({tag, "_pc"},    128'(out_pc),    128'(pc));
        check({tag, "_inst"},  out_inst,        data);
        check({tag, "_mask"},  128'(out_mask),  128'(mask));
        check({tag, "_exc"},   128'(out_exc),   128'(exc));
    endtask

    task automatic check_zero_outs(input string tag);
        check({tag, "_req"},   128'(inst_req),       128'(0));
        check({tag, "_valid"}, 128'(out_valid),      128'(0));
        check({tag, "_pc"},    128'(out_pc),         128'(0));
        check({tag, "_inst"},  out_inst,             128'(0));
        check({tag, "_mask"},  128'(out_mask),       128'(0));
        check({tag, "_exc"},   128'(out_exc),        128'(0));
        check({tag, "_perf"},  128'(perf_stall_cnt), 128'(0));
        check({tag, "_tag"},   128'(inst_tag),       128'(20'hBFC00));
        check({tag, "_state"}, 128'(dut.state_q),    128'(ST_REQ));
        check({tag, "_disc"},  128'(dut.discard_q),  128'(0));
    endtask

    int req_hi;

    initial begin
        rst            = 1'b0;
        inst_index_ok  = 1'b1;
        inst_data_ok   = 1'b0;
        inst_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        out_ready      = 1'b0;

        // Reset state and tied-off icache fields.
        repeat (2) @(posedge clk);
        #1;
        check_zero_outs("rst");
        check("rst_index",   128'(inst_index),        128'(8'h00));
        check("rst_uncache", 128'(inst_unCache),      128'(1));
        check("tie_size",    128'(inst_size),         128'(2'b10));
        check("tie_wr",      128'(inst_wr),           128'(0));
        check("tie_wdata",   128'(inst_wdata),        128'(0));
        check("tie_hasexc",  128'(inst_hasException), 128'(0));

        // First request on the first edge after release.
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("first_req",   128'(inst_req),     128'(1));
        check("first_index", 128'(inst_index),   128'(8'h00));
        check("first_tag",   128'(inst_tag),     128'(20'hBFC00));
        check("first_unc",   128'(inst_unCache), 128'(1));

        // Fill the queue with out_ready low.
        fetch_one("f0", 128'hA0A0);
        check_head("f0", 32'hBFC0_0000, 128'hA0A0, 4'b1111, 1'b0);
        check("f0_next_index", 128'(inst_index), 128'(8'h01));
        fetch_one("f1", 128'hA1A1);
        fetch_one("f2", 128'hA2A2);
        fetch_one("f3", 128'hA3A3);
        check("fill_req_low", 128'(inst_req), 128'(0));
        check_head("fill_head", 32'hBFC0_0000, 128'hA0A0, 4'b1111, 1'b0);

        req_hi = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (inst_req === 1'b1) req_hi++;
        end
        check("stall_req_cnt", 128'(req_hi),        128'(0));
        check("stall_state",   128'(dut.state_q),   128'(ST_FULL));
        check("stall_count",   128'(dut.fq_count),  128'(4));
`ifdef IFU_PERF_CNT_EN
        check("stall_perf_nz", 128'(perf_stall_cnt != 0), 128'(1));
`else
        check("stall_perf",    128'(perf_stall_cnt), 128'(0));
`endif

        // One pop: order preserved, request returns two cycles later.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_head("pop1", 32'hBFC0_0010, 128'hA1A1, 4'b1111, 1'b0);
        check("pop1_req",   128'(inst_req),      128'(0));
        check("pop1_state", 128'(dut.state_q),   128'(ST_FULL));
        tick();
        check("pop2c_req",   128'(inst_req),   128'(1));
        check("pop2c_index", 128'(inst_index), 128'(8'h04));
        tick();
        check("acc_state", 128'(dut.state_q), 128'(ST_WAIT));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_head("pop2", 32'hBFC0_0020, 128'hA2A2, 4'b1111, 1'b0);

        // Redirect during WAIT: flush, discard the owed line, refetch new pc.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0008;
        tick();
        redirect_valid = 1'b0;
        check("rd_valid",   128'(out_valid),     128'(0));
        check("rd_disc",    128'(dut.discard_q), 128'(1));
        check("rd_req",     128'(inst_req),      128'(0));
        check("rd_index",   128'(inst_index),    128'(8'h00));
        check("rd_tag",     128'(inst_tag),      128'(20'h80000));
        check("rd_unc",     128'(inst_unCache),  128'(0));
        tick();
        check("rd_hold_req", 128'(inst_req), 128'(0));
        inst_data_ok = 1'b1;
        inst_rdata   = 128'hDEAD;
        tick();
        inst_data_ok = 1'b0;
        check("rd_drop_valid", 128'(out_valid),     128'(0));
        check("rd_drop_disc",  128'(dut.discard_q), 128'(0));
        fetch_one("rd_f", 128'hB0B0);
        check_head("rd_f", 32'h8000_0008, 128'hB0B0, 4'b1100, 1'b0);

        // Redirect, push and pop together: queue ends empty.
        tick();
        check("rpp_wait", 128'(dut.state_q), 128'(ST_WAIT));
        inst_data_ok   = 1'b1;
        inst_rdata     = 128'hB1B1;
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_1000;
        tick();
        inst_data_ok   = 1'b0;
        out_ready      = 1'b0;
        redirect_valid = 1'b0;
        check("rpp_valid", 128'(out_valid),     128'(0));
        check("rpp_count", 128'(dut.fq_count),  128'(0));
        check("rpp_disc",  128'(dut.discard_q), 128'(0));
        check("rpp_req",   128'(inst_req),      128'(1));
        check("rpp_tag",   128'(inst_tag),      128'(20'h80001));

        // Redirect to a misaligned pc in the same cycle the request is accepted.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0002;
        tick();
        redirect_valid = 1'b0;
        check("mis_disc", 128'(dut.discard_q), 128'(1));
        check("mis_req",  128'(inst_req),      128'(0));
        tick();
        check("mis_wait_valid", 128'(out_valid), 128'(0));
        inst_data_ok = 1'b1;
        inst_rdata   = 128'hBEEF;
        tick();
        inst_data_ok = 1'b0;
        check("mis_drop_valid", 128'(out_valid), 128'(0));
        check("mis_drop_req",   128'(inst_req),  128'(0));
        tick();
        check_head("mis_exc", 32'h8000_0002, 128'h0, 4'b0000, 1'b1);
        check("mis_state", 128'(dut.state_q), 128'(ST_HALT));
        req_hi = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (inst_req === 1'b1) req_hi++;
        end
        check("halt_req_cnt", 128'(req_hi),       128'(0));
        check("halt_state",   128'(dut.state_q),  128'(ST_HALT));
        check("halt_count",   128'(dut.fq_count), 128'(1));

        // Redirect out of HALT to a word-3 offset.
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_010C;
        tick();
        redirect_valid = 1'b0;
        check("unhalt_state", 128'(dut.state_q), 128'(ST_REQ));
        check("unhalt_req",   128'(inst_req),    128'(1));
        check("unhalt_index", 128'(inst_index),  128'(8'h10));
        check("unhalt_valid", 128'(out_valid),   128'(0));
        fetch_one("w3", 128'hC0C0);
        check_head("w3", 32'h8000_010C, 128'hC0C0, 4'b1000, 1'b0);
        check("w3_next_index", 128'(inst_index), 128'(8'h11));

        // Asynchronous reset in the middle of WAIT.
        tick();
        check("prerst_state", 128'(dut.state_q), 128'(ST_WAIT));
        #2;
        rst = 1'b0;
        #1;
        check_zero_outs("arst");
        @(negedge clk);
        rst = 1'b1;
        tick();
        check("rest_req",   128'(inst_req),   128'(1));
        check("rest_index", 128'(inst_index), 128'(8'h00));
        check("rest_tag",   128'(inst_tag),   128'(20'hBFC00));
        fetch_one("rest_f", 128'hD0D0);
        check_head("rest_f", 32'hBFC0_0000, 128'hD0D0, 4'b1111, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
